clock_divider_bank: RTL and testbench



---
 rtl/clock_divider_bank_pkg.sv | 16 +
 rtl/clock_divider_bank_channel.sv | 80 ++++++++
 rtl/clock_divider_bank.sv | 62 ++++++
 tb/tb_clock_divider_bank.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/clock_divider_bank_pkg.sv
// Shared constants for the divider bank: default widths and production divisors for a 100 MHz reference.
package clock_divider_bank_pkg;

    localparam int unsigned CNT_W_DEF  = 23;
    localparam int unsigned REF_CLK_HZ = 100_000_000;

    // Divisor giving a 50%-duty output of out_hz: period is 2*(div+1) reference cycles.
    function automatic int unsigned div_for_hz(input int unsigned out_hz);
        return (REF_CLK_HZ / (2 * out_hz)) - 1;
    endfunction

    localparam logic [CNT_W_DEF-1:0] DEFAULT_DIV_DEF = 23'd4999999;
    localparam logic [CNT_W_DEF-1:0] DIV_10HZ        = CNT_W_DEF'(div_for_hz(10));
    localparam logic [CNT_W_DEF-1:0] DIV_1KHZ        = CNT_W_DEF'(div_for_hz(1000));

endpackage

// File: rtl/clock_divider_bank_channel.sv
// One divider channel: counter, active/shadow divisor, 50%-duty clock and wrap tick.
module clock_divider_bank_channel #(
    parameter int unsigned       CNT_W       = 23,
    parameter logic [CNT_W-1:0]  DEFAULT_DIV = '0
) (
    input  logic             clkIn,
    input  logic             rst,
    input  logic             en,
    input  logic             resync,
    input  logic             load,
    input  logic [CNT_W-1:0] ld_div,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_active_q, div_active_d;
    logic [CNT_W-1:0] div_shadow_q, div_shadow_d;
    logic             pending_q, pending_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    // Wrap samples pending_q, so a load landing on the wrap edge waits for the next wrap.
    always_comb begin
        cnt_d        = cnt_q;
        div_active_d = div_active_q;
        div_shadow_d = div_shadow_q;
        pending_d    = pending_q;
        clk_d        = clk_q;
        tick_d       = 1'b0;

        if (resync) begin
            cnt_d        = '0;
            clk_d        = 1'b0;
            div_active_d = div_shadow_q;
            pending_d    = 1'b0;
        end else if (en) begin
            if (cnt_q == div_active_q) begin
                cnt_d  = '0;
                clk_d  = ~clk_q;
                tick_d = 1'b1;
                if (pending_q) begin
                    div_active_d = div_shadow_q;
                    pending_d    = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (load) begin
            div_shadow_d = ld_div;
            pending_d    = 1'b1;
        end
    end

    always_ff @(posedge clkIn) begin
        if (rst) begin
            cnt_q        <= '0;
            div_active_q <= DEFAULT_DIV;
            div_shadow_q <= DEFAULT_DIV;
            pending_q    <= 1'b0;
            clk_q        <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            div_active_q <= div_active_d;
            div_shadow_q <= div_shadow_d;
            pending_q    <= pending_d;
            clk_q        <= clk_d;
            tick_q       <= tick_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign pending = pending_q;

endmodule

// File: rtl/clock_divider_bank.sv
// Multi-channel programmable clock divider with runtime divisor loads applied at each channel's wrap.
module clock_divider_bank
    import clock_divider_bank_pkg::*;
#(
    parameter int unsigned      CHANNELS    = 4,
    parameter int unsigned      CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF),
    parameter int unsigned      CH_W        = 2
) (
    input  logic                clkIn,
    input  logic                rst,
    input  logic                en,
    input  logic                resync,
    input  logic                ld_valid,
    input  logic [CH_W-1:0]     ld_chan,
    input  logic [CNT_W-1:0]    ld_div,
    output logic                ld_ready,
    output logic [CHANNELS-1:0] clkOut,
    output logic [CHANNELS-1:0] tick
);

    localparam int unsigned SLOTS = 1 << CH_W;

    if (SLOTS < CHANNELS) begin : g_bad_ch_w
        $error("CH_W too narrow for CHANNELS");
    end

    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] ld_stb;
    logic [SLOTS-1:0]    busy;

    // Unpopulated channel slots read as busy so out-of-range loads are never accepted.
    for (genvar g = 0; g < SLOTS; g++) begin : g_busy
        if (g < CHANNELS) begin : g_live
            assign busy[g] = pending[g];
        end else begin : g_empty
            assign busy[g] = 1'b1;
        end
    end

    assign ld_ready = ~busy[ld_chan];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign ld_stb[g] = ld_valid && ld_ready && (ld_chan == CH_W'(g));

        clock_divider_bank_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clkIn   (clkIn),
            .rst     (rst),
            .en      (en),
            .resync  (resync),
            .load    (ld_stb[g]),
            .ld_div  (ld_div),
            .clk_out (clkOut[g]),
            .tick    (tick[g]),
            .pending (pending[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank: a 4-channel and a 3-channel instance share all stimulus.
module tb_clock_divider_bank;

    localparam int unsigned CNT_W = 8;

    logic             clkIn = 1'b0;
    logic             rst, en, resync, ld_valid;
    logic [1:0]       ld_chan;
    logic [CNT_W-1:0] ld_div;
    logic             ld_ready4, ld_ready3;
    logic [3:0]       clk_out4, tick4;
    logic [2:0]       clk_out3, tick3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clkIn = ~clkIn;

    clock_divider_bank #(
        .CHANNELS(4), .CNT_W(CNT_W), .DEFAULT_DIV(8'd3), .CH_W(2)
    ) u_dut4 (
        .clkIn(clkIn), .rst(rst), .en(en), .resync(resync),
        .ld_valid(ld_valid), .ld_chan(ld_chan), .ld_div(ld_div),
        .ld_ready(ld_ready4), .clkOut(clk_out4), .tick(tick4)
    );

    clock_divider_bank #(
        .CHANNELS(3), .CNT_W(CNT_W), .DEFAULT_DIV(8'd3), .CH_W(2)
    ) u_dut3 (
        .clkIn(clkIn), .rst(rst), .en(en), .resync(resync),
        .ld_valid(ld_valid), .ld_chan(ld_chan), .ld_div(ld_div),
        .ld_ready(ld_ready3), .clkOut(clk_out3), .tick(tick3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clkIn);
        #1;
    endtask

    task automatic outs(input string tag, input logic [3:0] exp_tick, input logic [3:0] exp_clk);
        check({tag, ".tick"}, 32'(tick4), 32'(exp_tick));
        check({tag, ".clk"},  32'(clk_out4), 32'(exp_clk));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; resync = 1'b0;
        ld_valid = 1'b0; ld_chan = 2'd0; ld_div = '0;

        cyc(2);
        outs("reset", 4'h0, 4'h0);
        check("reset.ready", 32'(ld_ready4), 32'd1);

        // default divisor 3: tick every 4 cycles, clkOut period 8
        rst = 1'b0; en = 1'b1;
        cyc(3); outs("t1.e3", 4'h0, 4'h0);
        cyc(1); outs("t1.e4", 4'hF, 4'hF);
        cyc(1); outs("t1.e5", 4'h0, 4'hF);
        cyc(3); outs("t1.e8", 4'hF, 4'h0);

        // load ch1 div=1 mid-count; second load blocked until the wrap
        cyc(1);
        ld_valid = 1'b1; ld_chan = 2'd1; ld_div = 8'd1; #1;
        check("t2.ready_before", 32'(ld_ready4), 32'd1);
        cyc(1);
        ld_div = 8'd2; #1;
        check("t2.ready_blocked", 32'(ld_ready4), 32'd0);
        cyc(1);
        check("t2.ready_blocked2", 32'(ld_ready4), 32'd0);
        check("t2.e11.tick", 32'(tick4), 32'd0);
        ld_valid = 1'b0;
        cyc(1); outs("t2.e12", 4'hF, 4'hF);
        check("t2.ready_after", 32'(ld_ready4), 32'd1);
        cyc(1); outs("t2.e13", 4'h0, 4'hF);
        cyc(1); outs("t2.e14", 4'b0010, 4'b1101);
        cyc(2); outs("t2.e16", 4'hF, 4'b0010);

        // div=0 on ch2
        ld_valid = 1'b1; ld_chan = 2'd2; ld_div = 8'd0;
        cyc(1); ld_valid = 1'b0;
        cyc(3); outs("t3.e20", 4'hF, 4'hF);
        cyc(1); outs("t3.e21", 4'b0100, 4'b1011);
        cyc(1); outs("t3.e22", 4'b0110, 4'b1101);

        // freeze for 5 cycles
        en = 1'b0;
        cyc(1); outs("t4.e23", 4'h0, 4'b1101);
        cyc(4); outs("t4.e27", 4'h0, 4'b1101);
        en = 1'b1;
        cyc(1); outs("t4.e28", 4'b0100, 4'b1001);
        cyc(1); outs("t4.e29", 4'hF, 4'b0110);

        // pending load on ch0, then resync on ch3's wrap edge
        ld_valid = 1'b1; ld_chan = 2'd0; ld_div = 8'd1;
        cyc(1); ld_valid = 1'b0;
        cyc(2); resync = 1'b1;
        cyc(1); resync = 1'b0;
        outs("t5.e33", 4'h0, 4'h0);
        check("t5.ready_ch0", 32'(ld_ready4), 32'd1);
        cyc(1); outs("t5.e34", 4'b0100, 4'b0100);
        cyc(1); outs("t5.e35", 4'b0111, 4'b0011);
        check("t5.e35.clk3ch", 32'(clk_out3), 32'(3'b011));
        check("t5.e35.tick3ch", 32'(tick3), 32'(3'b111));

        // load ch1 on its wrap edge: applies only at the second wrap
        cyc(1);
        ld_valid = 1'b1; ld_chan = 2'd1; ld_div = 8'd3; #1;
        check("t6.ready_ch1", 32'(ld_ready4), 32'd1);
        cyc(1); ld_valid = 1'b0;
        check("t6.e37.tick1", 32'(tick4[1]), 32'd1);
        check("t6.e37.pending", 32'(ld_ready4), 32'd0);
        cyc(2);
        check("t6.e39.tick1", 32'(tick4[1]), 32'd1);
        check("t6.e39.clk1", 32'(clk_out4[1]), 32'd1);
        cyc(2);
        check("t6.e41.tick1", 32'(tick4[1]), 32'd0);
        cyc(2);
        check("t6.e43.tick1", 32'(tick4[1]), 32'd1);
        check("t6.e43.clk1", 32'(clk_out4[1]), 32'd0);

        // channel 3 is out of range only for the 3-channel instance
        ld_valid = 1'b1; ld_chan = 2'd3; ld_div = 8'd0; #1;
        check("t6.oor.ready3", 32'(ld_ready3), 32'd0);
        check("t6.inr.ready4", 32'(ld_ready4), 32'd1);
        cyc(1);
        check("t6.oor.ready3_after", 32'(ld_ready3), 32'd0);
        check("t6.inr.ready4_after", 32'(ld_ready4), 32'd0);
        ld_valid = 1'b0;

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
